// File: rtl/uart_tx_8n1_pkg.sv
// Shared UART types and defaults.
// Used by the transmitter and the matching receiver.
package uart_tx_8n1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_tx_8n1_baud_tick.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles.
// A load strobe restarts the period from zero.
module uart_tx_8n1_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic bit_end_o
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (load_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first, idle-high line.
// One-entry holding register lets frames run back to back.
module uart_tx_8n1
  import uart_tx_8n1_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 TX,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  tx_state_e state_q, state_d;

  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 hold_full_q, hold_full_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;

  logic bit_end;
  logic accept;
  logic load;
  logic last_bit;

  assign accept   = tx_valid && !hold_full_q;
  assign last_bit = (bit_cnt_q == BW'(DATA_BITS - 1));

  // Reload from IDLE, or chain straight from the end of STOP.
  assign load = hold_full_q &&
    ((state_q == ST_IDLE) ||
     ((state_q == ST_STOP) && bit_end));

  uart_tx_8n1_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk_i    (sys_clk),
    .rst_ni   (reset_n),
    .load_i   (hold_full_q && (state_q == ST_IDLE)),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) state_d = ST_START;
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && last_bit) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = hold_full_q ? ST_START : ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: ;
      ST_START: begin
        if (bit_end) tx_d = shift_q[0];
      end
      ST_DATA: begin
        if (bit_end) begin
          if (last_bit) begin
            tx_d = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      ST_STOP: begin
        done_d = bit_end;
      end
    endcase
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
      tx_d        = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign TX       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !hold_full_q;
  assign tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1 at 16 and 4 clocks per bit.
// Line-level frame model predicts TX/ready/busy/done every cycle.
module tb_uart_tx_8n1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vld [2];
  logic [7:0] dat [2];
  logic       rdy [2];
  logic       txl [2];
  logic       bsy [2];
  logic       dne [2];

  int n_chk = 0;
  int n_pass = 0;

  int cpb [2] = '{16, 4};

  bit       m_busy [2];
  bit       m_hfull [2];
  bit       m_done [2];
  logic [7:0] m_hold [2];
  logic [7:0] m_cur [2];
  int       m_t [2];

  always #5 clk = ~clk;

  uart_tx_8n1 #(.CLKS_PER_BIT(16)) u_d16 (
    .sys_clk (clk),
    .reset_n (reset_n),
    .tx_data (dat[0]),
    .tx_valid(vld[0]),
    .tx_ready(rdy[0]),
    .TX      (txl[0]),
    .tx_busy (bsy[0]),
    .tx_done (dne[0])
  );

  uart_tx_8n1 #(.CLKS_PER_BIT(4)) u_d4 (
    .sys_clk (clk),
    .reset_n (reset_n),
    .tx_data (dat[1]),
    .tx_valid(vld[1]),
    .tx_ready(rdy[1]),
    .TX      (txl[1]),
    .tx_busy (bsy[1]),
    .tx_done (dne[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // Frame = 10 bit slots: start 0, data LSB first, stop 1.
  function automatic logic exp_tx(input int d);
    int slot;
    if (!m_busy[d]) return 1'b1;
    slot = m_t[d] / cpb[d];
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[d][slot-1];
  endfunction

  task automatic model_step(input int d);
    bit acc;
    acc = vld[d] && !m_hfull[d];
    m_done[d] = 0;
    if (!reset_n) begin
      m_busy[d] = 0;
      m_hfull[d] = 0;
      m_t[d] = 0;
      return;
    end
    if (m_busy[d]) begin
      m_t[d]++;
      if (m_t[d] == 10 * cpb[d]) begin
        m_done[d] = 1;
        m_busy[d] = 0;
      end
    end
    if (!m_busy[d] && m_hfull[d]) begin
      m_busy[d] = 1;
      m_t[d] = 0;
      m_cur[d] = m_hold[d];
      m_hfull[d] = 0;
    end
    if (acc) begin
      m_hfull[d] = 1;
      m_hold[d] = dat[d];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) model_step(d);
      #1;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d tx t=%0t", d, $time),
              32'(txl[d]), 32'(exp_tx(d)));
        check($sformatf("d%0d ready", d),
              32'(rdy[d]), 32'(!m_hfull[d]));
        check($sformatf("d%0d busy", d),
              32'(bsy[d]), 32'(m_busy[d]));
        check($sformatf("d%0d done", d),
              32'(dne[d]), 32'(m_done[d]));
      end
    end
  end

  // Holds valid until accepted; optionally churns data while stalled.
  task automatic send(input int d, input logic [7:0] b,
                      input bit scramble);
    int n;
    n = 0;
    @(negedge clk);
    vld[d] = 1'b1;
    dat[d] = b;
    while (!rdy[d]) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
      if (scramble && !rdy[d]) dat[d] = 8'($urandom);
    end
    @(posedge clk);
    #1 vld[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (bsy[d] || !rdy[d]) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check("idle_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0;
      dat[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fork
      begin
        send(0, 8'hA5, 0);
        wait_idle(0);
        send(0, 8'h4B, 0);
        send(0, 8'hD2, 1);
        wait_idle(0);
        send(0, 8'h00, 0);
        send(0, 8'hFF, 0);
        send(0, 8'h55, 0);
        send(0, 8'hAA, 0);
        wait_idle(0);
        for (int i = 0; i < 6; i++) begin
          send(0, 8'($urandom), 1);
          if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 200)) @(negedge clk);
        end
        wait_idle(0);
      end
      begin
        send(1, 8'h96, 0);
        wait_idle(1);
        for (int i = 0; i < 10; i++) begin
          send(1, 8'($urandom), 1);
          if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 50)) @(negedge clk);
        end
        wait_idle(1);
      end
    join
    fork
      send(0, 8'h3C, 0);
      send(1, 8'hC3, 0);
    join
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst tx", d), 32'(txl[d]), 32'd1);
      check($sformatf("d%0d rst ready", d),
            32'(rdy[d]), 32'd1);
      check($sformatf("d%0d rst busy", d),
            32'(bsy[d]), 32'd0);
      check($sformatf("d%0d rst done", d),
            32'(dne[d]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    fork
      send(0, 8'h81, 0);
      send(1, 8'h7E, 0);
    join
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
